// File: rtl/line_clear_pkg.sv
// Shared definitions for the line-clear stage: default board geometry,
// FSM state encoding and a helper for sizing the row pointer.
package line_clear_pkg;

  localparam int DEF_MEM_WIDTH  = 10;
  localparam int DEF_MEM_HEIGHT = 20;
  localparam int DEF_WIDTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to index rows 0..height-1 (never less than one).
  function automatic int ptr_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/line_clear_row_shift_down.sv
// Combinational row removal: drops row `row` from the field, every row above
// it moves down by one and row 0 (the top) is refilled with zeros.
module row_shift_down
  import line_clear_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
  parameter int PTR_W      = ptr_width(DEF_MEM_HEIGHT)
) (
  input  logic [MEM_WIDTH*MEM_HEIGHT-1:0] field,
  input  logic [PTR_W-1:0]                row,
  output logic [MEM_WIDTH*MEM_HEIGHT-1:0] shifted
);

  // Rows below the removed one keep their content; rows at or above it take
  // the row above; row 0 stays at the zero default.
  always_comb begin
    shifted = '0;
    for (int r = 0; r < MEM_HEIGHT; r++) begin
      if (PTR_W'(r) > row) begin
        shifted[r*MEM_WIDTH +: MEM_WIDTH] = field[r*MEM_WIDTH +: MEM_WIDTH];
      end else if (r > 0) begin
        shifted[r*MEM_WIDTH +: MEM_WIDTH] = field[(r-1)*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

endmodule

// File: rtl/line_clear.sv
// Line-elimination stage: takes a locked board, scans it bottom-up one row
// per cycle, collapses every full row and reports how many were removed,
// keeping a saturating running total for scoring.
module line_clear
  import line_clear_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [MEM_WIDTH*MEM_HEIGHT-1:0] field_in,
  output logic                            busy,
  output logic                            done,
  output logic [MEM_WIDTH*MEM_HEIGHT-1:0] field_out,
  output logic [WIDTH-1:0]                lines_cleared,
  output logic [WIDTH-1:0]                total_lines
);

  localparam int FW    = MEM_WIDTH * MEM_HEIGHT;
  localparam int PTR_W = ptr_width(MEM_HEIGHT);
  localparam logic [PTR_W-1:0] PTR_BOTTOM = PTR_W'(MEM_HEIGHT - 1);

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [FW-1:0]      field_q, field_next, field_shifted;
  logic [WIDTH-1:0]   lc_q, lc_next;
  logic [WIDTH-1:0]   total_q, total_next;
  logic               busy_q, busy_next;
  logic               done_q, done_next;
  logic               row_full;
  logic [WIDTH:0]     total_sum;

  row_shift_down #(
    .MEM_WIDTH  (MEM_WIDTH),
    .MEM_HEIGHT (MEM_HEIGHT),
    .PTR_W      (PTR_W)
  ) u_shift (
    .field   (field_q),
    .row     (ptr),
    .shifted (field_shifted)
  );

  // Reduction-AND of the row currently addressed by the scan pointer.
  always_comb begin
    row_full = 1'b0;
    for (int r = 0; r < MEM_HEIGHT; r++) begin
      if (PTR_W'(r) == ptr) begin
        row_full = &field_q[r*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  // One extra bit catches overflow so the running total can saturate.
  assign total_sum = {1'b0, total_q} + {1'b0, lc_q};

  // Next-state and datapath decisions for the IDLE/SCAN/DONE sequence.
  always_comb begin
    // NOTE: every target gets a default before the case so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_next = state;
    ptr_next   = ptr;
    field_next = field_q;
    lc_next    = lc_q;
    total_next = total_q;
    busy_next  = busy_q;
    done_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          field_next = field_in;
          ptr_next   = PTR_BOTTOM;
          lc_next    = '0;
          busy_next  = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (row_full) begin
          // Pointer stays put: the row that dropped in must be examined too.
          field_next = field_shifted;
          lc_next    = lc_q + WIDTH'(1);
        end else if (ptr != '0) begin
          ptr_next = ptr - PTR_W'(1);
        end else begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        total_next = total_sum[WIDTH] ? '1 : total_sum[WIDTH-1:0];
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= PTR_BOTTOM;
      // NOTE: the field register is wide storage but is still reset, because
      // field_out must read as an empty board straight after reset.
      field_q <= '0;
      lc_q    <= '0;
      total_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      field_q <= field_next;
      lc_q    <= lc_next;
      total_q <= total_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign field_out     = field_q;
  assign lines_cleared = lc_q;
  assign total_lines   = total_q;

endmodule
